// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and defaults for the memory arbiter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_D_WAIT  = 2'b01,
      ST_IF_WAIT = 2'b10,
      ST_RESP    = 2'b11
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 16;
   localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-cycle counter flagging the last cycle before timeout
module wait_timer
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Saturates at LAST so a late-arriving ack never sees a wrapped count.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one memory port, data has priority
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_ready,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             bus_err
);

   state_e           state_q, state_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic             if_ready_q, if_ready_d;
   logic             d_ready_q, d_ready_d;
   logic             bus_err_q, bus_err_d;
   logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic             in_wait;
   logic             timer_expired;

   assign in_wait = (state_q == ST_D_WAIT) || (state_q == ST_IF_WAIT);

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_wait),
      .enable  (in_wait && !mem_ack),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         bus_err_q   <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
         bus_err_q   <= bus_err_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (d_req) begin
               state_d = ST_D_WAIT;
            end else if (if_req) begin
               state_d = ST_IF_WAIT;
            end
         end
         ST_D_WAIT, ST_IF_WAIT: begin
            if (mem_ack || timer_expired) begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs are computed one cycle ahead; ack beats a coincident timeout.
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (d_req) begin
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end else if (if_req) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
            end
         end
         ST_D_WAIT: begin
            if (mem_ack || timer_expired) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               d_ready_d = 1'b1;
               bus_err_d = !mem_ack;
               if (!mem_we_q) begin
                  d_rdata_d = mem_ack ? mem_rdata : '0;
               end
            end
         end
         ST_IF_WAIT: begin
            if (mem_ack || timer_expired) begin
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               if_ready_d = 1'b1;
               bus_err_d  = !mem_ack;
               if_rdata_d = mem_ack ? mem_rdata : '0;
            end
         end
         default: ;
      endcase
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ready  = if_ready_q;
   assign d_ready   = d_ready_q;
   assign bus_err   = bus_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        bus_err;

   int total = 0;
   int bad = 0;

   mem_arbiter #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   // Transaction-level model: one access in flight, aged per cycle, then one response cycle.
   bit          m_busy, m_data, m_write, m_resp;
   int          m_age;
   logic        e_mem_req, e_mem_we, e_if_ready, e_d_ready, e_bus_err;
   logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 0; m_data <= 0; m_write <= 0; m_resp <= 0; m_age <= 0;
         e_mem_req <= 0; e_mem_we <= 0; e_mem_addr <= '0; e_mem_wdata <= '0;
         e_if_ready <= 0; e_d_ready <= 0; e_bus_err <= 0;
         e_if_rdata <= '0; e_d_rdata <= '0;
      end else begin
         e_if_ready <= 0;
         e_d_ready  <= 0;
         e_bus_err  <= 0;
         if (m_resp) begin
            m_resp <= 0;
         end else if (!m_busy) begin
            if (d_req) begin
               m_busy <= 1; m_data <= 1; m_write <= d_we; m_age <= 0;
               e_mem_req <= 1; e_mem_we <= d_we; e_mem_addr <= d_addr; e_mem_wdata <= d_wdata;
            end else if (if_req) begin
               m_busy <= 1; m_data <= 0; m_write <= 0; m_age <= 0;
               e_mem_req <= 1; e_mem_we <= 0; e_mem_addr <= if_addr;
            end
         end else if (mem_ack || m_age == TO - 1) begin
            m_busy <= 0; m_resp <= 1;
            e_mem_req <= 0; e_mem_we <= 0;
            e_bus_err <= !mem_ack;
            if (m_data) begin
               e_d_ready <= 1;
               if (!m_write) e_d_rdata <= mem_ack ? mem_rdata : 32'h0;
            end else begin
               e_if_ready <= 1;
               e_if_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("mem_req",   32'(mem_req),   32'(e_mem_req));
      check("mem_we",    32'(mem_we),    32'(e_mem_we));
      check("mem_addr",  mem_addr,       e_mem_addr);
      check("mem_wdata", mem_wdata,      e_mem_wdata);
      check("if_ready",  32'(if_ready),  32'(e_if_ready));
      check("d_ready",   32'(d_ready),   32'(e_d_ready));
      check("bus_err",   32'(bus_err),   32'(e_bus_err));
      check("if_rdata",  if_rdata,       e_if_rdata);
      check("d_rdata",   d_rdata,        e_d_rdata);
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_ready(input int max, output int n);
      n = 0;
      while (!(if_ready || d_ready) && n < max) begin
         step();
         n++;
      end
      check("ready_seen", 32'(if_ready || d_ready), 32'd1);
   endtask

   initial begin
      int n;
      step();
      step();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      reset = 1'b1;
      step();

      // Fetch only
      if_req = 1; if_addr = 32'h40;
      step();
      check("f_mem_req", 32'(mem_req), 32'd1);
      check("f_mem_addr", mem_addr, 32'h40);
      check("f_mem_we", 32'(mem_we), 32'd0);
      if_req = 0; mem_ack = 1; mem_rdata = 32'h2108000A;
      step();
      check("f_if_ready", 32'(if_ready), 32'd1);
      check("f_if_rdata", if_rdata, 32'h2108000A);
      check("f_mem_req_resp", 32'(mem_req), 32'd0);
      mem_ack = 0;
      step();
      check("f_if_ready_pulse", 32'(if_ready), 32'd0);
      step();

      // Simultaneous data load and fetch: data wins
      d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h80;
      step();
      check("s_mem_addr_d", mem_addr, 32'h100);
      mem_ack = 1; mem_rdata = 32'h11112222;
      step();
      check("s_d_ready", 32'(d_ready), 32'd1);
      check("s_if_ready", 32'(if_ready), 32'd0);
      check("s_d_rdata", d_rdata, 32'h11112222);
      d_req = 0; mem_ack = 0;
      step();
      step();
      check("s_mem_addr_if", mem_addr, 32'h80);
      check("s_mem_req_if", 32'(mem_req), 32'd1);
      mem_ack = 1; mem_rdata = 32'h33334444;
      step();
      check("s_if_ready2", 32'(if_ready), 32'd1);
      check("s_if_rdata2", if_rdata, 32'h33334444);
      if_req = 0; mem_ack = 0;
      step();

      // Store with ack in the fourth wait cycle
      d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
      step();
      d_req = 0; d_we = 0; d_wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         check("w_mem_we", 32'(mem_we), 32'd1);
         check("w_mem_addr", mem_addr, 32'h20);
         check("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
         if (i == 3) begin
            mem_ack = 1; mem_rdata = 32'h99999999;
         end
         step();
      end
      check("w_d_ready", 32'(d_ready), 32'd1);
      check("w_d_rdata_kept", d_rdata, 32'h11112222);
      mem_ack = 0;
      step();

      // Fetch timeout
      if_req = 1; if_addr = 32'h44; mem_rdata = 32'hFFFF0000;
      step();
      if_req = 0;
      wait_ready(40, n);
      check("t_latency", 32'(n + 1), 32'd17);
      check("t_bus_err", 32'(bus_err), 32'd1);
      check("t_if_rdata", if_rdata, 32'h0);
      step();
      check("t_bus_err_pulse", 32'(bus_err), 32'd0);

      // Data load with ack in the last allowed wait cycle
      d_req = 1; d_addr = 32'h200;
      step();
      d_req = 0;
      for (int i = 0; i < TO - 1; i++) step();
      mem_ack = 1; mem_rdata = 32'hCAFE0001;
      step();
      check("a_d_ready", 32'(d_ready), 32'd1);
      check("a_bus_err", 32'(bus_err), 32'd0);
      check("a_d_rdata", d_rdata, 32'hCAFE0001);
      mem_ack = 0;
      step();

      // Data load timeout clears d_rdata
      d_req = 1; d_addr = 32'h204;
      step();
      d_req = 0;
      wait_ready(40, n);
      check("dt_bus_err", 32'(bus_err), 32'd1);
      check("dt_d_rdata", d_rdata, 32'h0);
      step();

      // Reset mid-wait, then a stray ack
      if_req = 1; if_addr = 32'h48;
      step();
      if_req = 0;
      step();
      #3 reset = 0;
      step();
      check("r_mem_req", 32'(mem_req), 32'd0);
      reset = 1; mem_ack = 1; mem_rdata = 32'h77777777;
      step();
      step();
      check("r_if_ready", 32'(if_ready), 32'd0);
      check("r_mem_req2", 32'(mem_req), 32'd0);
      check("r_if_rdata", if_rdata, 32'h0);
      if_req = 1; if_addr = 32'h4C; mem_rdata = 32'h55;
      step();
      if_req = 0;
      step();
      check("r_refetch_ready", 32'(if_ready), 32'd1);
      check("r_refetch_rdata", if_rdata, 32'h55);
      mem_ack = 0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
